// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package rx_frame_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    StHunt,
    StSfd,
    StHdr,
    StPay,
    StCrc
  } rx_state_e;

  // Start-of-frame delimiter that follows the alternating preamble
  localparam logic [7:0] SfdByte = 8'hAB;

  // CRC-8 polynomial x^8+x^2+x+1
  localparam logic [7:0] CrcPoly = 8'h07;

  // All-ones broadcast address for an id_w-bit ID field
  function automatic logic [31:0] broadcast_id(input int unsigned id_w);
    if (id_w >= 32) begin
      return '1;
    end
    return (32'd1 << id_w) - 32'd1;
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB first, init 0, no reflection, no final XOR).
module crc8_serial
  import rx_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [7:0] crc_out
);

  logic [7:0] crc_q, crc_d;
  logic       feedback;

  // Next CRC value: clear has priority over a shift
  always_comb begin
    feedback = crc_q[7] ^ data_in;
    crc_d    = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (feedback ? CrcPoly : 8'h00);
    end
  end

  // CRC register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/rx_frame_receiver_p.sv
// Parametrised serial frame receiver: preamble/SFD hunt, header and payload
// deserialisation, CRC-8 check, address filter and a single output buffer.
module rx_frame_receiver_p
  import rx_frame_pkg::*;
#(
  parameter int unsigned ID_W     = 2,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned PRE_BITS = 16,
  parameter int unsigned CRC_HDR  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_line,
  input  logic                        rx_valid,
  input  logic [ID_W-1:0]             my_id,
  input  logic                        promisc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ID_W-1:0]             dest_id,
  output logic [ID_W-1:0]             src_id,
  output logic [LEN_W:0]              pay_len,
  output logic [8*(2**LEN_W)-1:0]     payload,
  output logic                        crc_err,
  output logic                        addr_drop,
  output logic                        overrun
);

  localparam int unsigned MaxBytes = 2 ** LEN_W;
  localparam int unsigned PayW     = 8 * MaxBytes;
  localparam int unsigned HW       = 2 * ID_W + LEN_W;
  localparam int unsigned CntW     = LEN_W + 4;
  localparam logic [PRE_BITS-1:0] PrePattern = {(PRE_BITS / 2){2'b10}};
  localparam logic [ID_W-1:0]     BcastId    = ID_W'(broadcast_id(ID_W));

  rx_state_e state_q, state_d;

  // The oldest preamble bit is only needed for the compare, so it is not stored
  logic [PRE_BITS-2:0] pre_q, pre_d;
  logic [PRE_BITS-1:0] pre_shift;
  logic                prev_q, prev_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [HW-1:0]       hdr_q, hdr_d;
  logic [PayW-1:0]     pay_q, pay_d;
  logic [6:0]          crc_rx_q, crc_rx_d;
  logic [7:0]          rx_byte;
  logic [7:0]          crc_calc;

  logic [ID_W-1:0]  sh_dest, sh_src;
  logic [LEN_W-1:0] sh_len;
  logic hdr_last, pay_last, crc_last;
  logic crc_clr, crc_en, frame_done;
  logic crc_ok, addr_ok, busy, load;

  logic              out_valid_q;
  logic [ID_W-1:0]   dest_q, src_q;
  logic [LEN_W:0]    pay_len_q;
  logic [PayW-1:0]   payload_q;
  logic              crc_err_q, addr_drop_q, overrun_q;

  // Field decode and end-of-phase conditions
  always_comb begin
    pre_shift = {pre_q, rx_line};
    rx_byte   = {crc_rx_q, rx_line};
    sh_dest   = hdr_q[HW-1 -: ID_W];
    sh_src    = hdr_q[LEN_W +: ID_W];
    sh_len    = hdr_q[LEN_W-1:0];
    hdr_last  = (cnt_q == CntW'(HW - 1));
    // (len+1)*8-1 == len*8+7
    pay_last  = (cnt_q == {1'b0, sh_len, 3'b111});
    crc_last  = (cnt_q[2:0] == 3'd7);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; nothing moves without a bit strobe
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      unique case (state_q)
        StHunt: if (pre_shift == PrePattern) state_d = StSfd;
        StSfd: begin
          if ({prev_q, rx_line} == SfdByte[1:0]) begin
            state_d = StHdr;
          end else if (!prev_q && !rx_line) begin
            state_d = StHunt;
          end
        end
        StHdr:   if (hdr_last) state_d = StPay;
        StPay:   if (pay_last) state_d = StCrc;
        StCrc:   if (crc_last) state_d = StHunt;
        default: state_d = StHunt;
      endcase
    end
  end

  // FSM outputs: CRC engine control and frame completion strobe
  always_comb begin
    crc_clr    = rx_valid && (state_q == StHunt || state_q == StSfd);
    crc_en     = rx_valid && (state_q == StPay || (state_q == StHdr && CRC_HDR != 0));
    frame_done = rx_valid && (state_q == StCrc) && crc_last;
  end

  // Datapath next-state: preamble, bit counter and shadow shift registers
  always_comb begin
    pre_d    = pre_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    pay_d    = pay_q;
    crc_rx_d = crc_rx_q;
    if (rx_valid) begin
      unique case (state_q)
        StHunt: begin
          pre_d  = pre_shift[PRE_BITS-2:0];
          prev_d = rx_line;
        end
        StSfd: begin
          prev_d = rx_line;
          cnt_d  = '0;
          // Leaving SFD either way: next hunt starts from a clean register
          if (prev_q == rx_line) pre_d = '0;
        end
        StHdr: begin
          hdr_d = {hdr_q[HW-2:0], rx_line};
          cnt_d = hdr_last ? '0 : cnt_q + 1'b1;
          if (hdr_last) pay_d = '0;
        end
        StPay: begin
          pay_d = {pay_q[PayW-2:0], rx_line};
          cnt_d = pay_last ? '0 : cnt_q + 1'b1;
        end
        StCrc: begin
          crc_rx_d = rx_byte[6:0];
          cnt_d    = crc_last ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q    <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      hdr_q    <= '0;
      pay_q    <= '0;
      crc_rx_q <= '0;
    end else begin
      pre_q    <= pre_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      pay_q    <= pay_d;
      crc_rx_q <= crc_rx_d;
    end
  end

  crc8_serial u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (crc_clr),
    .enable  (crc_en),
    .data_in (rx_line),
    .crc_out (crc_calc)
  );

  // Completion outcome, highest priority first: CRC, address, buffer busy
  always_comb begin
    crc_ok  = (rx_byte == crc_calc);
    addr_ok = promisc || (sh_dest == my_id) || (sh_dest == BcastId);
    busy    = out_valid_q && !out_ready;
    load    = frame_done && crc_ok && addr_ok && !busy;
  end

  // Output buffer and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dest_q      <= '0;
      src_q       <= '0;
      pay_len_q   <= '0;
      payload_q   <= '0;
      crc_err_q   <= 1'b0;
      addr_drop_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= load || (out_valid_q && !out_ready);
      if (load) begin
        dest_q    <= sh_dest;
        src_q     <= sh_src;
        pay_len_q <= {1'b0, sh_len} + 1'b1;
        payload_q <= pay_q;
      end
      crc_err_q   <= frame_done && !crc_ok;
      addr_drop_q <= frame_done && crc_ok && !addr_ok;
      overrun_q   <= frame_done && crc_ok && addr_ok && busy;
    end
  end

  assign out_valid = out_valid_q;
  assign dest_id   = dest_q;
  assign src_id    = src_q;
  assign pay_len   = pay_len_q;
  assign payload   = payload_q;
  assign crc_err   = crc_err_q;
  assign addr_drop = addr_drop_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rx_frame_receiver_p.sv
// Scoreboard bench for rx_frame_receiver_p: a legacy-CRC instance (dut0) and a
// header-inclusive-CRC instance (dut1) see the same serial stream.
module tb_rx_frame_receiver_p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_line = 1'b0;
  logic rx_valid = 1'b0;
  logic [1:0] my_id = 2'd1;
  logic promisc = 1'b0;
  logic out_ready = 1'b1;

  logic         ov0, ce0, ad0, or0, ov1, ce1, ad1, or1;
  logic [1:0]   de0, sr0, de1, sr1;
  logic [4:0]   pl0, pl1;
  logic [127:0] py0, py1;

  always #5 clk = ~clk;

  rx_frame_receiver_p #(.ID_W(2), .LEN_W(4), .PRE_BITS(16), .CRC_HDR(0)) u_dut_leg (
    .clk(clk), .rst_n(rst_n), .rx_line(rx_line), .rx_valid(rx_valid), .my_id(my_id),
    .promisc(promisc), .out_valid(ov0), .out_ready(out_ready), .dest_id(de0), .src_id(sr0),
    .pay_len(pl0), .payload(py0), .crc_err(ce0), .addr_drop(ad0), .overrun(or0)
  );

  rx_frame_receiver_p #(.ID_W(2), .LEN_W(4), .PRE_BITS(16), .CRC_HDR(1)) u_dut_hdr (
    .clk(clk), .rst_n(rst_n), .rx_line(rx_line), .rx_valid(rx_valid), .my_id(my_id),
    .promisc(promisc), .out_valid(ov1), .out_ready(out_ready), .dest_id(de1), .src_id(sr1),
    .pay_len(pl1), .payload(py1), .crc_err(ce1), .addr_drop(ad1), .overrun(or1)
  );

  // kind: 0 accept, 1 crc_err, 2 addr_drop, 3 overrun, 4 nothing expected, 5 multi-pulse
  typedef struct {
    int           kind;
    logic [1:0]   dest;
    logic [1:0]   src;
    logic [4:0]   len;
    logic [127:0] pay;
  } ev_t;

  ev_t exp_q0[$];
  ev_t exp_q1[$];
  int n_checks = 0;
  int n_pass = 0;

  logic [7:0]   pay_buf [16];
  logic [1:0]   f_dest, f_src;
  logic [4:0]   f_len;
  logic [127:0] f_pay;
  bit           f_crc_ok [2];
  bit           f_addr_ok;
  bit           model_full [2];
  bit           prev_v [2];
  bit           prev_rdy;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  function automatic logic [7:0] calc_crc(input logic [1:0] dest, input logic [1:0] src,
                                          input logic [3:0] len, input bit hdr_incl);
    logic [7:0] c;
    c = 8'h00;
    if (hdr_incl) c = crc8_byte(c, {dest, src, len});
    for (int i = 0; i <= int'(len); i++) c = crc8_byte(c, pay_buf[i]);
    return c;
  endfunction

  // One clock of stimulus; on the final CRC bit the outcome for each DUT is predicted
  task automatic step(input logic b, input logic v, input bit last);
    rx_line  = b;
    rx_valid = v;
    for (int d = 0; d < 2; d++) begin : per_dut
      bit  busy, hs, ld;
      ev_t e;
      busy = model_full[d] && !out_ready;
      hs   = model_full[d] && out_ready;
      ld   = 1'b0;
      if (last && v) begin
        e.dest = f_dest;
        e.src  = f_src;
        e.len  = f_len;
        e.pay  = f_pay;
        if (!f_crc_ok[d]) e.kind = 1;
        else if (!f_addr_ok) e.kind = 2;
        else if (busy) e.kind = 3;
        else begin
          e.kind = 0;
          ld = 1'b1;
        end
        if (d == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
      end
      model_full[d] = ld ? 1'b1 : (hs ? 1'b0 : model_full[d]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    model_full[0] = 1'b0;
    model_full[1] = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, " dut0 out_valid"}, 128'(ov0), 128'(0));
    check_eq({tag, " dut0 fields"}, 128'({de0, sr0, pl0}), 128'(0));
    check_eq({tag, " dut0 payload"}, py0, 128'(0));
    check_eq({tag, " dut0 pulses"}, 128'({ce0, ad0, or0}), 128'(0));
    check_eq({tag, " dut1 out_valid"}, 128'(ov1), 128'(0));
    check_eq({tag, " dut1 fields"}, 128'({de1, sr1, pl1}), 128'(0));
    check_eq({tag, " dut1 payload"}, py1, 128'(0));
    check_eq({tag, " dut1 pulses"}, 128'({ce1, ad1, or1}), 128'(0));
  endtask

  // max_bits < 0 sends the whole frame; last_rdy >= 0 sets out_ready for the final bit
  task automatic send_frame(input logic [1:0] dest, input logic [1:0] src, input logic [3:0] len,
                            input logic [7:0] crc_byte, input int gap, input int max_bits,
                            input int last_rdy);
    logic       bits [$];
    logic [7:0] byte_v;
    int         n;
    f_dest = dest;
    f_src  = src;
    f_len  = 5'(len) + 5'd1;
    f_pay  = '0;
    for (int i = 0; i <= int'(len); i++) f_pay = (f_pay << 8) | 128'(pay_buf[i]);
    f_crc_ok[0] = (calc_crc(dest, src, len, 1'b0) == crc_byte);
    f_crc_ok[1] = (calc_crc(dest, src, len, 1'b1) == crc_byte);
    f_addr_ok   = promisc || (dest == my_id) || (dest == 2'b11);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(1'b1);
      bits.push_back(1'b0);
    end
    byte_v = 8'hAB;
    for (int i = 7; i >= 0; i--) bits.push_back(byte_v[i]);
    byte_v = {dest, src, len};
    for (int i = 7; i >= 0; i--) bits.push_back(byte_v[i]);
    for (int j = 0; j <= int'(len); j++) begin
      byte_v = pay_buf[j];
      for (int i = 7; i >= 0; i--) bits.push_back(byte_v[i]);
    end
    for (int i = 7; i >= 0; i--) bits.push_back(crc_byte[i]);
    n = (max_bits < 0) ? bits.size() : max_bits;
    for (int i = 0; i < n; i++) begin
      bit is_last;
      is_last = (i == bits.size() - 1);
      idle(gap);
      if (is_last && last_rdy >= 0) out_ready = 1'(last_rdy);
      step(bits[i], 1'b1, is_last);
    end
  endtask

  task automatic observe(input int d, input logic v, input logic ce, input logic ad,
                         input logic orr, input logic [1:0] de, input logic [1:0] sr,
                         input logic [4:0] pl, input logic [127:0] py);
    int  kind;
    bit  any;
    ev_t e;
    any = 1'b1;
    if ($countones({ce, ad, orr}) > 1) kind = 5;
    else if (ce) kind = 1;
    else if (ad) kind = 2;
    else if (orr) kind = 3;
    else if (v && (!prev_v[d] || prev_rdy)) kind = 0;
    else begin
      kind = 4;
      any  = 1'b0;
    end
    if (any) begin
      e.kind = 4;
      if (d == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
      else if (d == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
      check_eq($sformatf("dut%0d event kind", d), 128'(kind), 128'(e.kind));
      if (kind == 0 && e.kind == 0) begin
        check_eq($sformatf("dut%0d dest_id", d), 128'(de), 128'(e.dest));
        check_eq($sformatf("dut%0d src_id", d), 128'(sr), 128'(e.src));
        check_eq($sformatf("dut%0d pay_len", d), 128'(pl), 128'(e.len));
        check_eq($sformatf("dut%0d payload", d), py, e.pay);
      end
    end
    prev_v[d] = v;
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
      prev_rdy  = 1'b0;
    end else begin
      observe(0, ov0, ce0, ad0, or0, de0, sr0, pl0, py0);
      observe(1, ov1, ce1, ad1, or1, de1, sr1, pl1, py1);
      prev_rdy = out_ready;
    end
  end

  initial begin
    logic [1:0]   held_dest;
    logic [127:0] held_pay;

    do_reset();
    check_reset("reset");

    // Reference frame: header 0x61, payload A5 3C, CRC ED
    pay_buf[0] = 8'hA5;
    pay_buf[1] = 8'h3C;
    send_frame(2'd1, 2'd2, 4'd1, 8'hED, 0, -1, -1);
    idle(3);
    send_frame(2'd1, 2'd2, 4'd1, 8'hEC, 0, -1, -1);
    idle(3);

    // Address filter: broadcast, miss, promiscuous, then header-inclusive CRC
    send_frame(2'd3, 2'd2, 4'd1, calc_crc(2'd3, 2'd2, 4'd1, 1'b0), 0, -1, -1);
    idle(2);
    send_frame(2'd2, 2'd0, 4'd1, calc_crc(2'd2, 2'd0, 4'd1, 1'b0), 0, -1, -1);
    idle(2);
    promisc = 1'b1;
    send_frame(2'd2, 2'd0, 4'd1, calc_crc(2'd2, 2'd0, 4'd1, 1'b0), 0, -1, -1);
    idle(2);
    promisc = 1'b0;
    send_frame(2'd1, 2'd2, 4'd1, calc_crc(2'd1, 2'd2, 4'd1, 1'b1), 0, -1, -1);
    idle(3);

    // Back-to-back frames with the consumer stalled: second one overruns
    out_ready  = 1'b0;
    pay_buf[0] = 8'h11;
    pay_buf[1] = 8'h22;
    send_frame(2'd1, 2'd0, 4'd1, calc_crc(2'd1, 2'd0, 4'd1, 1'b0), 0, -1, -1);
    held_dest  = f_dest;
    held_pay   = f_pay;
    pay_buf[0] = 8'h33;
    pay_buf[1] = 8'h44;
    send_frame(2'd3, 2'd3, 4'd1, calc_crc(2'd3, 2'd3, 4'd1, 1'b0), 0, -1, -1);
    idle(3);
    check_eq("held out_valid", 128'(ov0), 128'(1));
    check_eq("held dest_id", 128'(de0), 128'(held_dest));
    check_eq("held payload", py0, held_pay);
    out_ready = 1'b1;
    idle(3);

    // Same pair, consumer ready exactly as the second frame completes
    out_ready  = 1'b0;
    pay_buf[0] = 8'h55;
    pay_buf[1] = 8'h66;
    send_frame(2'd1, 2'd0, 4'd1, calc_crc(2'd1, 2'd0, 4'd1, 1'b0), 0, -1, -1);
    pay_buf[0] = 8'h77;
    pay_buf[1] = 8'h88;
    send_frame(2'd3, 2'd1, 4'd1, calc_crc(2'd3, 2'd1, 4'd1, 1'b0), 0, -1, 1);
    idle(3);

    // Maximum length, one strobe in four
    for (int i = 0; i < 16; i++) pay_buf[i] = 8'(i);
    send_frame(2'd1, 2'd1, 4'd15, calc_crc(2'd1, 2'd1, 4'd15, 1'b0), 3, -1, -1);
    idle(3);

    // "00" inside the preamble: back to hunt, no outcome
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0);
    idle(3);
    check_eq("after 00 dut0 out_valid", 128'(ov0), 128'(0));
    check_eq("after 00 dut1 out_valid", 128'(ov1), 128'(0));
    pay_buf[0] = 8'h9C;
    pay_buf[1] = 8'h01;
    send_frame(2'd1, 2'd3, 4'd1, calc_crc(2'd1, 2'd3, 4'd1, 1'b1), 0, -1, -1);
    idle(3);

    // Reset mid-payload while a frame is held in the buffer
    out_ready = 1'b0;
    send_frame(2'd1, 2'd3, 4'd1, calc_crc(2'd1, 2'd3, 4'd1, 1'b0), 0, -1, -1);
    send_frame(2'd1, 2'd3, 4'd1, calc_crc(2'd1, 2'd3, 4'd1, 1'b0), 0, 36, -1);
    do_reset();
    check_reset("mid-frame reset");
    out_ready = 1'b1;
    send_frame(2'd1, 2'd2, 4'd1, calc_crc(2'd1, 2'd2, 4'd1, 1'b0), 0, -1, -1);
    idle(5);

    check_eq("dut0 pending events", 128'(exp_q0.size()), 128'(0));
    check_eq("dut1 pending events", 128'(exp_q1.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
